// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: HD44780-compatible device end of the LCD character bus.
// Ports:
//   clk, reset_n        - system clock, synchronous active-low reset
//   LCD_E/RS/RW         - host strobe, register select, read/write (asynchronous)
//   LCD_data_in         - bus value sampled from the pad
//   LCD_data_out/_oe    - read-return value and pad output enable
//   scan_addr/scan_data - registered DDRAM mirror read port
//   cursor_addr         - address counter (AC)
//   display_on/cursor_on/blink_on - display control bits D, C, B
//   busy                - busy flag (BF)
//   ignored_access      - one-cycle pulse when a write arrives while busy
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES      = 2000,
    parameter int BUSY_LONG_CYCLES = 76500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_data_in,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    input  logic [6:0] scan_addr,
    output logic [7:0] scan_data,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       ignored_access
);
    localparam int MAXC = BUSY_LONG_CYCLES > BUSY_CYCLES ? BUSY_LONG_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SHORT_LD = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(BUSY_LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, FILL, WAIT} state_t;
    state_t state, state_nx;

    logic [7:0]    mem [128];
    logic [10:0]   sync1, sync2, prev;
    logic [9:0]    op;
    logic [6:0]    fill_cnt, fill_addr;
    logic [CW-1:0] wcnt;
    logic          id, cgram, fall, start, drop_wr, fill_we, data_we, is_clear, is_home;

    function automatic logic [6:0] ac_inc(input logic [6:0] a);
        return a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a);
        return a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1;
    endfunction

    // Gap addresses snap to the start of the following line
    function automatic logic [6:0] clamp(input logic [6:0] a);
        return a[5:0] < 6'd40 ? a : (a[6] ? 7'h00 : 7'h40);
    endfunction

    // Falling edge uses the previous-cycle snapshot, taken while E was still high
    assign fall     = prev[10] & ~sync2[10];
    assign start    = fall && state == IDLE && !(!prev[9] && prev[8]);
    assign drop_wr  = fall && state != IDLE && !prev[8];
    assign is_clear = !op[9] && op[7:0] == 8'h01;
    assign is_home  = !op[9] && op[7:1] == 7'h01;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= FILL;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && start)                state_nx = EXEC;
        else if (state == EXEC)                    state_nx = is_clear ? FILL : WAIT;
        else if (state == FILL && fill_cnt == 7'd79) state_nx = WAIT;
        else if (state == WAIT && wcnt == '0)      state_nx = IDLE;
    end

    always_comb begin
        busy      = state != IDLE;
        fill_we   = state == FILL;
        data_we   = state == EXEC && op[9] && !op[8] && !cgram;
        fill_addr = fill_cnt < 7'd40 ? fill_cnt : fill_cnt + 7'd24;
    end

    always_ff @(posedge clk) begin
        if (fill_we)      mem[fill_addr] <= 8'h20;
        else if (data_we) mem[cursor_addr] <= op[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1          <= '0;
            sync2          <= '0;
            prev           <= '0;
            op             <= '0;
            fill_cnt       <= '0;
            wcnt           <= '0;
            cursor_addr    <= '0;
            id             <= 1'b1;
            cgram          <= 1'b0;
            display_on     <= 1'b0;
            cursor_on      <= 1'b0;
            blink_on       <= 1'b0;
            ignored_access <= 1'b0;
            LCD_data_oe    <= 1'b0;
            LCD_data_out   <= 8'h00;
            scan_data      <= 8'h20;
        end else begin
            sync1          <= {LCD_E, LCD_RS, LCD_RW, LCD_data_in};
            sync2          <= sync1;
            prev           <= sync2;
            ignored_access <= drop_wr;
            if (start) op <= prev[9:0];
            LCD_data_oe  <= sync2[10] & sync2[8];
            LCD_data_out <= !(sync2[10] & sync2[8]) ? 8'h00 :
                            !sync2[9] ? {busy, cursor_addr} :
                            cgram ? 8'h00 : mem[cursor_addr];
            scan_data <= scan_addr[5:0] < 6'd40 ? mem[scan_addr] : 8'h20;
            fill_cnt  <= state == FILL ? fill_cnt + 7'd1 : 7'd0;
            if (state == EXEC)      wcnt <= is_home ? LONG_LD : SHORT_LD;
            else if (state == FILL) wcnt <= LONG_LD;
            else if (state == WAIT) wcnt <= wcnt - 1'b1;
            if (state == EXEC) begin
                if (op[9]) begin
                    if (!cgram) cursor_addr <= id ? ac_inc(cursor_addr) : ac_dec(cursor_addr);
                end else if (op[7]) begin
                    cgram       <= 1'b0;
                    cursor_addr <= clamp(op[6:0]);
                end else if (op[6]) begin
                    cgram <= 1'b1;
                end else if (!op[5]) begin
                    if (op[4]) begin
                        if (!op[3]) cursor_addr <= op[2] ? ac_inc(cursor_addr) : ac_dec(cursor_addr);
                    end else if (op[3]) begin
                        {display_on, cursor_on, blink_on} <= op[2:0];
                    end else if (op[2]) begin
                        id <= op[1];
                    end else if (op[1]) begin
                        cursor_addr <= 7'h00;
                    end else if (op[0]) begin
                        cursor_addr <= 7'h00;
                        id          <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed table-driven bench for lcd_hd44780_responder.
module tb_lcd_hd44780_responder;
    localparam int BC = 10;
    localparam int BLC = 50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_din = 8'h00;
    logic [7:0] lcd_dout;
    logic       lcd_oe;
    logic [6:0] scan_addr = 7'h00;
    logic [7:0] scan_data;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, blink_on, busy, ignored_access;

    int checks = 0;
    int fails = 0;
    int ign_cnt = 0;

    lcd_hd44780_responder #(.BUSY_CYCLES(BC), .BUSY_LONG_CYCLES(BLC)) dut (
        .clk(clk), .reset_n(reset_n), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
        .LCD_data_in(lcd_din), .LCD_data_out(lcd_dout), .LCD_data_oe(lcd_oe),
        .scan_addr(scan_addr), .scan_data(scan_data), .cursor_addr(cursor_addr),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .busy(busy), .ignored_access(ignored_access)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ignored_access) ign_cnt <= ign_cnt + 1;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] exp_ac;
        logic [6:0] chk_addr;
        logic [7:0] exp_scan;
        int         exp_busy;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_din = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] v, output logic oe);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        v = lcd_dout; oe = lcd_oe;
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_done(output int n);
        int t = 0;
        while (!busy && t < 40) begin @(negedge clk); t++; end
        check("busy_rise", busy, 1);
        n = 0;
        while (busy && n < 1000) begin n++; @(negedge clk); end
        check("busy_fall", busy, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 1000) begin @(negedge clk); t++; end
        check("idle_timeout", busy, 0);
    endtask

    task automatic scan(input logic [6:0] a, output logic [7:0] v);
        scan_addr = a;
        @(negedge clk);
        v = scan_data;
    endtask

    initial begin
        int n, bad, ign0;
        logic [7:0] v;
        logic oe;
        vecs = '{
            '{1'b0, 8'hA6, 7'h26, 7'h26, 8'h20, 1 + BC},
            '{1'b1, 8'h41, 7'h27, 7'h26, 8'h41, 1 + BC},
            '{1'b1, 8'h42, 7'h40, 7'h27, 8'h42, 1 + BC},
            '{1'b1, 8'h43, 7'h41, 7'h40, 8'h43, 1 + BC},
            '{1'b0, 8'h04, 7'h41, 7'h40, 8'h43, 1 + BC},
            '{1'b0, 8'h80, 7'h00, 7'h00, 8'h20, 1 + BC},
            '{1'b1, 8'h5A, 7'h67, 7'h00, 8'h5A, 1 + BC},
            '{1'b0, 8'h06, 7'h67, 7'h67, 8'h20, 1 + BC},
            '{1'b1, 8'h37, 7'h00, 7'h67, 8'h37, 1 + BC},
            '{1'b0, 8'hB0, 7'h40, 7'h40, 8'h43, 1 + BC},
            '{1'b0, 8'hE8, 7'h00, 7'h00, 8'h5A, 1 + BC},
            '{1'b0, 8'h14, 7'h01, 7'h01, 8'h20, 1 + BC},
            '{1'b0, 8'h10, 7'h00, 7'h00, 8'h5A, 1 + BC},
            '{1'b0, 8'h10, 7'h67, 7'h67, 8'h37, 1 + BC},
            '{1'b0, 8'h18, 7'h67, 7'h67, 8'h37, 1 + BC},
            '{1'b0, 8'h40, 7'h67, 7'h67, 8'h37, 1 + BC},
            '{1'b1, 8'h99, 7'h67, 7'h67, 8'h37, 1 + BC},
            '{1'b0, 8'hA7, 7'h27, 7'h27, 8'h42, 1 + BC},
            '{1'b0, 8'h38, 7'h27, 7'h27, 8'h42, 1 + BC},
            '{1'b0, 8'h0C, 7'h27, 7'h27, 8'h42, 1 + BC},
            '{1'b0, 8'h03, 7'h00, 7'h00, 8'h5A, 1 + BLC}
        };

        repeat (3) @(negedge clk);
        check("rst_oe", lcd_oe, 0);
        check("rst_dout", lcd_dout, 8'h00);
        check("rst_scan", scan_data, 8'h20);
        check("rst_ac", cursor_addr, 0);
        check("rst_dcb", {display_on, cursor_on, blink_on}, 0);
        check("rst_busy", busy, 1);
        check("rst_ign", ignored_access, 0);
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 1000) begin n++; @(negedge clk); end
        check("rst_busy_len", n, 80 + BLC);
        bus_read(1'b0, v, oe);
        check("rst_status", v, 8'h00);
        check("rst_status_oe", oe, 1);
        scan(7'h00, v); check("rst_scan00", v, 8'h20);
        scan(7'h27, v); check("rst_scan27", v, 8'h20);
        scan(7'h40, v); check("rst_scan40", v, 8'h20);
        scan(7'h67, v); check("rst_scan67", v, 8'h20);
        scan(7'h30, v); check("scan_invalid", v, 8'h20);

        for (int i = 0; i < 21; i++) begin
            bus_write(vecs[i].rs, vecs[i].d);
            wait_done(n);
            check($sformatf("vec%0d_busy", i), n, vecs[i].exp_busy);
            check($sformatf("vec%0d_ac", i), cursor_addr, vecs[i].exp_ac);
            scan(vecs[i].chk_addr, v);
            check($sformatf("vec%0d_scan", i), v, vecs[i].exp_scan);
        end
        check("dcb_0c", {display_on, cursor_on, blink_on}, 3'b100);

        ign0 = ign_cnt;
        bus_write(1'b0, 8'h02);
        repeat (5) @(negedge clk);
        check("home_busy", busy, 1);
        bus_read(1'b0, v, oe);
        check("busy_status", v, 8'h80);
        bus_write(1'b1, 8'h77);
        wait_idle();
        repeat (2) @(negedge clk);
        check("ignored_once", ign_cnt - ign0, 1);
        check("ignored_ac", cursor_addr, 7'h00);
        scan(7'h00, v); check("ignored_mem", v, 8'h5A);

        bus_write(1'b0, 8'hB0);
        wait_done(n);
        check("clamp_ac", cursor_addr, 7'h40);
        bus_write(1'b0, 8'h0F);
        wait_done(n);
        check("dcb_0f", {display_on, cursor_on, blink_on}, 3'b111);
        bus_read(1'b1, v, oe);
        check("data_read", v, 8'h43);
        check("data_read_oe", oe, 1);
        wait_done(n);
        check("data_read_ac", cursor_addr, 7'h41);
        check("oe_released", lcd_oe, 0);

        bus_write(1'b0, 8'h04);
        wait_done(n);
        bus_write(1'b0, 8'h01);
        wait_done(n);
        check("clear_busy", n, 1 + 80 + BLC);
        check("clear_ac", cursor_addr, 7'h00);
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            scan(7'(a), v);
            if ((a & 63) < 40 && v !== 8'h20) bad++;
        end
        check("clear_scan_bad", bad, 0);
        bus_write(1'b1, 8'h61);
        wait_done(n);
        check("clear_id", cursor_addr, 7'h01);
        scan(7'h00, v); check("post_clear_mem", v, 8'h61);

        bus_write(1'b1, 8'h62);
        wait_done(n);
        bus_write(1'b1, 8'h63);
        n = 0;
        while (!busy && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_ac", cursor_addr, 7'h00);
        check("midrst_busy", busy, 1);
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 1000) begin n++; @(negedge clk); end
        check("midrst_busy_len", n, 80 + BLC);
        scan(7'h00, v); check("midrst_refill", v, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
